// File: rtl/fsk_framer.sv
// Link-layer framer: wraps fixed-length payloads in preamble, sync word, length byte and
// CRC-16/CCITT-FALSE trailer, with valid/ready on both sides and stall padding.
module fsk_framer #(
  parameter int unsigned PREAMBLE_LEN = 4,
  parameter logic [15:0] SYNC_WORD    = 16'h2DD4,
  parameter int unsigned PAYLOAD_LEN  = 16,
  parameter int unsigned TIMEOUT      = 65535,
  parameter logic [7:0]  PAD_BYTE     = 8'h00
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] data_in,
  input  logic       in_valid,
  output logic       in_ready,
  output logic [7:0] data_out,
  output logic       out_valid,
  input  logic       out_ready,
  output logic       busy,
  output logic       frame_done,
  output logic       timeout_err
);

  localparam logic [3:0]  PreLen     = 4'(PREAMBLE_LEN);
  localparam logic [7:0]  PayLen     = 8'(PAYLOAD_LEN);
  localparam logic [15:0] TimeoutVal = 16'(TIMEOUT);
  localparam bit          TimeoutEn  = (TIMEOUT != 0);

  typedef enum logic [3:0] {
    StIdle,
    StPreamble,
    StSyncHi,
    StSyncLo,
    StLen,
    StPayload,
    StPad,
    StCrcHi,
    StCrcLo
  } state_e;

  state_e      state_q, state_d;
  logic [7:0]  data_q, data_d;
  logic        valid_q, valid_d;
  logic        last_q, last_d;
  logic [3:0]  pre_cnt_q, pre_cnt_d;
  logic [7:0]  pay_cnt_q, pay_cnt_d;
  logic [15:0] idle_q, idle_d;
  logic [15:0] crc_q, crc_d;

  logic slot_free;
  logic in_xfer;
  logic idle_hit;

  function automatic logic [15:0] crc16_byte(input logic [15:0] crc, input logic [7:0] b);
    logic [15:0] c;
    c = crc ^ {b, 8'h00};
    for (int i = 0; i < 8; i++) begin
      c = c[15] ? ({c[14:0], 1'b0} ^ 16'h1021) : {c[14:0], 1'b0};
    end
    return c;
  endfunction

  assign slot_free  = !valid_q || out_ready;
  assign in_ready   = (state_q == StPayload) && slot_free;
  assign in_xfer    = in_valid && in_ready;
  assign idle_hit   = TimeoutEn && (idle_q >= TimeoutVal);
  assign data_out   = data_q;
  assign out_valid  = valid_q;
  assign busy       = (state_q != StIdle);
  // last_q marks the CRC_LO byte sitting in the output register
  assign frame_done = valid_q && out_ready && last_q;

  always_comb begin
    state_d     = state_q;
    data_d      = data_q;
    valid_d     = valid_q;
    last_d      = last_q;
    pre_cnt_d   = pre_cnt_q;
    pay_cnt_d   = pay_cnt_q;
    idle_d      = idle_q;
    crc_d       = crc_q;
    timeout_err = 1'b0;

    // Slot drains unless a state below reloads it this cycle.
    if (slot_free) begin
      valid_d = 1'b0;
      last_d  = 1'b0;
    end

    unique case (state_q)
      StIdle: begin
        if (in_valid) begin
          state_d   = StPreamble;
          pre_cnt_d = '0;
        end
      end
      StPreamble: begin
        if (slot_free) begin
          data_d  = 8'h55;
          valid_d = 1'b1;
          if (pre_cnt_q + 4'd1 == PreLen) begin
            pre_cnt_d = '0;
            state_d   = StSyncHi;
          end else begin
            pre_cnt_d = pre_cnt_q + 4'd1;
          end
        end
      end
      StSyncHi: begin
        if (slot_free) begin
          data_d  = SYNC_WORD[15:8];
          valid_d = 1'b1;
          state_d = StSyncLo;
        end
      end
      StSyncLo: begin
        if (slot_free) begin
          data_d  = SYNC_WORD[7:0];
          valid_d = 1'b1;
          state_d = StLen;
        end
      end
      StLen: begin
        if (slot_free) begin
          data_d    = PayLen;
          valid_d   = 1'b1;
          crc_d     = 16'hFFFF;
          pay_cnt_d = '0;
          idle_d    = '0;
          state_d   = StPayload;
        end
      end
      StPayload: begin
        if (in_xfer) begin
          data_d    = data_in;
          valid_d   = 1'b1;
          crc_d     = crc16_byte(crc_q, data_in);
          pay_cnt_d = pay_cnt_q + 8'd1;
          idle_d    = '0;
          if (pay_cnt_q + 8'd1 == PayLen) begin
            state_d = StCrcHi;
          end
        end else begin
          if (slot_free && !in_valid && (idle_q != 16'hFFFF)) begin
            idle_d = idle_q + 16'd1;
          end
          if (idle_hit) begin
            state_d     = StPad;
            timeout_err = 1'b1;
          end
        end
      end
      StPad: begin
        if (slot_free) begin
          data_d    = PAD_BYTE;
          valid_d   = 1'b1;
          crc_d     = crc16_byte(crc_q, PAD_BYTE);
          pay_cnt_d = pay_cnt_q + 8'd1;
          if (pay_cnt_q + 8'd1 == PayLen) begin
            state_d = StCrcHi;
          end
        end
      end
      StCrcHi: begin
        if (slot_free) begin
          data_d  = crc_q[15:8];
          valid_d = 1'b1;
          state_d = StCrcLo;
        end
      end
      StCrcLo: begin
        if (slot_free) begin
          data_d  = crc_q[7:0];
          valid_d = 1'b1;
          last_d  = 1'b1;
          state_d = StIdle;
        end
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= StIdle;
      data_q    <= '0;
      valid_q   <= 1'b0;
      last_q    <= 1'b0;
      pre_cnt_q <= '0;
      pay_cnt_q <= '0;
      idle_q    <= '0;
      crc_q     <= 16'hFFFF;
    end else begin
      state_q   <= state_d;
      data_q    <= data_d;
      valid_q   <= valid_d;
      last_q    <= last_d;
      pre_cnt_q <= pre_cnt_d;
      pay_cnt_q <= pay_cnt_d;
      idle_q    <= idle_d;
      crc_q     <= crc_d;
    end
  end

endmodule

// File: tb/tb_fsk_framer.sv
// Bench for fsk_framer: three configurations, a frame-level expected-byte model and one
// per-cycle compare process watching whichever instance is selected.
module tb_fsk_framer;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [7:0] din;
  logic [2:0] iv, ordy;
  logic [2:0] ir, ov, bsy, fd, te;
  logic [7:0] dout [3];

  always #5 clk = ~clk;

  // 0: PAYLOAD_LEN=9; 1: PAYLOAD_LEN=4 TIMEOUT=8; 2: PAYLOAD_LEN=4 TIMEOUT=0
  fsk_framer #(.PAYLOAD_LEN(9)) u_a (
    .clk(clk), .rst_n(rst_n), .data_in(din), .in_valid(iv[0]), .in_ready(ir[0]),
    .data_out(dout[0]), .out_valid(ov[0]), .out_ready(ordy[0]), .busy(bsy[0]),
    .frame_done(fd[0]), .timeout_err(te[0])
  );
  fsk_framer #(.PAYLOAD_LEN(4), .TIMEOUT(8)) u_b (
    .clk(clk), .rst_n(rst_n), .data_in(din), .in_valid(iv[1]), .in_ready(ir[1]),
    .data_out(dout[1]), .out_valid(ov[1]), .out_ready(ordy[1]), .busy(bsy[1]),
    .frame_done(fd[1]), .timeout_err(te[1])
  );
  fsk_framer #(.PAYLOAD_LEN(4), .TIMEOUT(0)) u_c (
    .clk(clk), .rst_n(rst_n), .data_in(din), .in_valid(iv[2]), .in_ready(ir[2]),
    .data_out(dout[2]), .out_valid(ov[2]), .out_ready(ordy[2]), .busy(bsy[2]),
    .frame_done(fd[2]), .timeout_err(te[2])
  );

  typedef struct packed {
    logic       first;
    logic       last;
    logic       pay;
    logic [7:0] b;
  } exp_t;

  exp_t        exp_q[$];
  logic [7:0]  pl_q[$];
  logic [15:0] last_crc;
  int total = 0, bad = 0;
  int sel = 0, cyc = 0;
  int n_done = 0, n_to = 0;
  int first_cyc = 0, done_cyc = 0, gap_cyc = 0, last_in_cyc = 0, to_cyc = 0;
  bit to_allowed = 0, rand_rdy = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // Bit-serial CRC-16/CCITT-FALSE over one byte.
  function automatic logic [15:0] crc_bits(input logic [15:0] crc, input logic [7:0] b);
    logic [15:0] c;
    logic        fb;
    c = crc;
    for (int i = 7; i >= 0; i--) begin
      fb = c[15] ^ b[i];
      c  = {c[14:0], 1'b0};
      if (fb) c = c ^ 16'h1021;
    end
    return c;
  endfunction

  // Append the full expected on-air frame; payload from pl_q, padded with 0x00 up to len.
  task automatic push_frame(input int unsigned len);
    exp_t        e;
    logic [15:0] crc;
    logic [7:0]  b;
    logic [7:0]  hdr [3];
    hdr[0] = 8'h2D;
    hdr[1] = 8'hD4;
    hdr[2] = 8'(len);
    for (int i = 0; i < 4; i++) begin
      e = '{first: (i == 0), last: 1'b0, pay: 1'b0, b: 8'h55};
      exp_q.push_back(e);
    end
    for (int i = 0; i < 3; i++) begin
      e = '{first: 1'b0, last: 1'b0, pay: 1'b0, b: hdr[i]};
      exp_q.push_back(e);
    end
    crc = 16'hFFFF;
    for (int i = 0; i < int'(len); i++) begin
      b   = (i < pl_q.size()) ? pl_q[i] : 8'h00;
      crc = crc_bits(crc, b);
      e   = '{first: 1'b0, last: 1'b0, pay: 1'b1, b: b};
      exp_q.push_back(e);
    end
    e = '{first: 1'b0, last: 1'b0, pay: 1'b0, b: crc[15:8]};
    exp_q.push_back(e);
    e = '{first: 1'b0, last: 1'b1, pay: 1'b0, b: crc[7:0]};
    exp_q.push_back(e);
    last_crc = crc;
  endtask

  task automatic send_byte(input logic [7:0] b);
    int n;
    n   = 0;
    din = b;
    iv  = 3'(1 << sel);
    forever begin
      @(negedge clk);
      if (ir[sel]) break;
      n++;
      if (n > 1000) begin
        chk("in_ready_wait", 32'(ir[sel]), 32'd1);
        break;
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic wait_done(input int target);
    int n;
    n = 0;
    while (n_done < target && n < 2000) begin
      @(negedge clk);
      n++;
    end
    @(posedge clk);
    #1;
    chk("frames_done", 32'(n_done), 32'(target));
    chk("queue_drained", 32'(exp_q.size()), 32'd0);
  endtask

  initial begin : rdy_gen
    forever begin
      @(posedge clk);
      #1;
      if (rand_rdy) ordy = ($urandom_range(0, 1) != 0) ? 3'(1 << sel) : 3'b000;
    end
  end

  initial begin : compare
    exp_t       e;
    int         k;
    logic       hp;
    logic [7:0] pd;
    hp = 1'b0;
    pd = '0;
    forever begin
      @(negedge clk);
      cyc++;
      if (!rst_n) begin
        hp = 1'b0;
      end else begin
        if (hp) begin
          chk("hold_valid", 32'(ov[sel]), 32'd1);
          chk("hold_data", 32'(dout[sel]), 32'(pd));
        end
        if (ov[sel] && !ordy[sel]) begin
          chk("in_ready_stall", 32'(ir[sel]), 32'd0);
        end else if (ir[sel]) begin
          k = ov[sel] ? 1 : 0;
          chk("in_ready_region", 32'((k < exp_q.size()) ? exp_q[k].pay : 1'b0), 32'd1);
          chk("busy", 32'(bsy[sel]), 32'd1);
        end
        if (iv[sel] && ir[sel]) last_in_cyc = cyc;
        if (ov[sel] && ordy[sel]) begin
          if (exp_q.size() == 0) begin
            total++;
            bad++;
            $display("FAIL extra_byte: got 0x%0h, expected no byte (cycle %0d)", dout[sel], cyc);
          end else begin
            e = exp_q.pop_front();
            chk("data_out", 32'(dout[sel]), 32'(e.b));
            chk("frame_done", 32'(fd[sel]), 32'(e.last));
            if (e.first) begin
              first_cyc = cyc;
              gap_cyc   = cyc - done_cyc;
            end
            if (e.last) begin
              done_cyc = cyc;
              n_done++;
            end
          end
        end else begin
          chk("frame_done_idle", 32'(fd[sel]), 32'd0);
        end
        if (te[sel]) begin
          n_to++;
          to_cyc = cyc;
        end
        if (!to_allowed) chk("timeout_err", 32'(te[sel]), 32'd0);
        hp = ov[sel] && !ordy[sel];
        pd = dout[sel];
      end
    end
  end

  initial begin : watchdog
    #400000;
    $display("FAIL watchdog: got no finish, expected finish (cycle %0d)", cyc);
    $fatal(1, "watchdog expired");
  end

  initial begin : stim
    rst_n = 1'b0;
    din   = '0;
    iv    = '0;
    ordy  = '0;
    #3;
    for (int i = 0; i < 3; i++) begin
      chk("rst_data_out", 32'(dout[i]), 32'd0);
      chk("rst_out_valid", 32'(ov[i]), 32'd0);
      chk("rst_in_ready", 32'(ir[i]), 32'd0);
      chk("rst_busy", 32'(bsy[i]), 32'd0);
      chk("rst_frame_done", 32'(fd[i]), 32'd0);
      chk("rst_timeout_err", 32'(te[i]), 32'd0);
    end
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    // 1: "123456789" at full throughput
    sel  = 0;
    ordy = 3'b001;
    n_done = 0;
    pl_q.delete();
    for (int i = 0; i < 9; i++) pl_q.push_back(8'h31 + 8'(i));
    push_frame(9);
    chk("model_crc", 32'(last_crc), 32'h29B1);
    chk("model_len", 32'(exp_q.size()), 32'd18);
    for (int i = 0; i < 9; i++) send_byte(8'h31 + 8'(i));
    iv = '0;
    wait_done(1);
    chk("no_gaps", 32'(done_cyc - first_cyc), 32'd17);

    // 2: same frame, random backpressure
    n_done = 0;
    push_frame(9);
    rand_rdy = 1;
    for (int i = 0; i < 9; i++) send_byte(8'h31 + 8'(i));
    iv = '0;
    wait_done(1);
    rand_rdy = 0;
    @(posedge clk);
    #2;
    ordy = '0;

    // 3: timeout after two bytes, two pad bytes
    sel  = 1;
    ordy = 3'b010;
    n_done = 0;
    n_to   = 0;
    to_allowed = 1;
    pl_q.delete();
    pl_q.push_back(8'hA5);
    pl_q.push_back(8'h3C);
    push_frame(4);
    send_byte(8'hA5);
    send_byte(8'h3C);
    iv = '0;
    wait_done(1);
    chk("timeout_pulses", 32'(n_to), 32'd1);
    chk("timeout_delay", 32'(to_cyc - last_in_cyc), 32'd9);
    to_allowed = 0;

    // 4: padding disabled, 40-cycle stall
    sel  = 2;
    ordy = 3'b100;
    n_done = 0;
    n_to   = 0;
    pl_q.delete();
    for (int i = 0; i < 4; i++) pl_q.push_back(8'h11 * 8'(i + 1));
    push_frame(4);
    send_byte(8'h11);
    send_byte(8'h22);
    iv = '0;
    repeat (40) @(posedge clk);
    #1;
    send_byte(8'h33);
    send_byte(8'h44);
    iv = '0;
    wait_done(1);
    chk("no_timeout", 32'(n_to), 32'd0);

    // 5: async reset mid-payload, then a fresh frame
    sel  = 0;
    ordy = 3'b001;
    pl_q.delete();
    for (int i = 0; i < 9; i++) pl_q.push_back(8'h31 + 8'(i));
    push_frame(9);
    send_byte(8'h31);
    send_byte(8'h32);
    send_byte(8'h33);
    din = 8'h34;
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_data_out", 32'(dout[0]), 32'd0);
    chk("arst_out_valid", 32'(ov[0]), 32'd0);
    chk("arst_in_ready", 32'(ir[0]), 32'd0);
    chk("arst_busy", 32'(bsy[0]), 32'd0);
    chk("arst_frame_done", 32'(fd[0]), 32'd0);
    exp_q.delete();
    iv = '0;
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    n_done = 0;
    pl_q.delete();
    for (int i = 0; i < 9; i++) pl_q.push_back(8'h41 + 8'(i));
    push_frame(9);
    for (int i = 0; i < 9; i++) send_byte(8'h41 + 8'(i));
    iv = '0;
    wait_done(1);

    // 6: two frames back to back
    n_done = 0;
    pl_q.delete();
    for (int i = 0; i < 9; i++) pl_q.push_back(8'h61 + 8'(i));
    push_frame(9);
    pl_q.delete();
    for (int i = 0; i < 9; i++) pl_q.push_back(8'h71 + 8'(i));
    push_frame(9);
    for (int i = 0; i < 9; i++) send_byte(8'h61 + 8'(i));
    for (int i = 0; i < 9; i++) send_byte(8'h71 + 8'(i));
    iv = '0;
    wait_done(2);
    chk("b2b_gap", 32'(gap_cyc), 32'd2);

    repeat (3) @(posedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
